// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite master: response codes and master FSM states.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } mst_state_e;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4_lite_master_p_if.sv
// AXI4-Lite bus bundle between one master and one slave.
interface axi4_lite_master_p_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );

endinterface

// File: rtl/axi4_lite_master_p_vhold.sv
// Per-channel VALID holder: set on load, held until the channel handshakes.
module axi_lite_vhold (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic load,
  input  logic ready,
  output logic valid
);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)            valid <= 1'b0;
    else if (load)           valid <= 1'b1;
    else if (valid && ready) valid <= 1'b0;
  end

endmodule

// File: rtl/axi4_lite_master_p.sv
// AXI4-Lite master: one command in flight, AW/W/B or AR/R, one held response per command.
module axi4_lite_master_p
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  axi4_lite_master_p_if.master axi
);

  localparam int unsigned STRB_W = DATA_W / 8;

  mst_state_e        state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              ar_valid_q;
  logic              b_ready_q;
  logic              r_ready_q;
  logic              aw_valid;
  logic              w_valid;

  logic accept_c;
  logic wr_load_c;
  logic aw_done_c;
  logic w_done_c;

  // A channel counts as done once its VALID has dropped or is handshaking this cycle.
  assign accept_c  = (state == IDLE) && cmd_ready && cmd_valid;
  assign wr_load_c = accept_c && cmd_write;
  assign aw_done_c = !aw_valid || axi.AWREADY;
  assign w_done_c  = !w_valid || axi.WREADY;

  axi_lite_vhold u_aw_hold (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .load    (wr_load_c),
    .ready   (axi.AWREADY),
    .valid   (aw_valid)
  );

  axi_lite_vhold u_w_hold (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .load    (wr_load_c),
    .ready   (axi.WREADY),
    .valid   (w_valid)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_resp   <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          // cmd_ready comes up one cycle after reset release
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            if (cmd_write) begin
              state <= WR;
            end else begin
              state      <= RD_ADDR;
              ar_valid_q <= 1'b1;
            end
          end
        end
        WR: begin
          if (aw_done_c && w_done_c) begin
            state     <= WR_RESP;
            b_ready_q <= 1'b1;
          end
        end
        WR_RESP: begin
          if (axi.BVALID) begin
            state     <= RSP;
            b_ready_q <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= axi.BRESP;
          end
        end
        RD_ADDR: begin
          if (axi.ARREADY) begin
            state      <= RD_DATA;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (axi.RVALID) begin
            state     <= RSP;
            r_ready_q <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= axi.RDATA;
            rsp_resp  <= axi.RRESP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign axi.AWADDR  = addr_q;
  assign axi.AWPROT  = PROT_DEFAULT;
  assign axi.AWVALID = aw_valid;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.WVALID  = w_valid;
  assign axi.BREADY  = b_ready_q;
  assign axi.ARADDR  = addr_q;
  assign axi.ARPROT  = PROT_DEFAULT;
  assign axi.ARVALID = ar_valid_q;
  assign axi.RREADY  = r_ready_q;

endmodule
